// File: rtl/cronometer_pkg.sv
// Shared types and default sizing for the cronometer timer bank.
package cronometer_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned CW_DEF  = 8;
  localparam int unsigned PSW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } ch_state_e;

endpackage

// File: rtl/cronometer_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every presc_div+1 cycles.
module cronometer_prescaler #(
  parameter int unsigned PSW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PSW-1:0] presc_div,
  output logic           tick
);

  logic [PSW-1:0] cnt_q;
  logic [PSW-1:0] cnt_d;

  // Terminal on >= so a divisor lowered below the running count wraps at once
  always_comb begin
    tick  = (cnt_q >= presc_div);
    cnt_d = tick ? '0 : cnt_q + PSW'(1);
  end

  // Prescaler counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cronometer_bank.sv
// Bank of NCH independent timer channels sharing one prescaler tick.
module cronometer_bank
  import cronometer_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned CW  = CW_DEF,
  parameter int unsigned PSW = PSW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PSW-1:0]    presc_div,
  input  logic [NCH-1:0]    select,
  input  logic [NCH-1:0]    oneshot,
  input  logic [NCH-1:0]    clear,
  input  logic [NCH*CW-1:0] period,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    running,
  output logic [NCH*CW-1:0] count
);

  logic tick;

  cronometer_prescaler #(
    .PSW(PSW)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .presc_div(presc_div),
    .tick     (tick)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e     state_q;
    ch_state_e     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          exp_q;
    logic          exp_d;
    logic          done_q;
    logic          done_d;
    logic [CW-1:0] per;

    assign per = period[i*CW +: CW];

    // Channel next-state: clear dominates; expiry goes through a one-cycle stage before done
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = 1'b0;
      done_d  = exp_q;
      if (clear[i]) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_d = '0;
            if (select[i]) begin
              state_d = RUN;
            end
          end
          RUN: begin
            if (select[i] && tick) begin
              if (cnt_q >= per) begin
                exp_d = 1'b1;
                if (oneshot[i]) begin
                  state_d = EXPIRED;
                end else begin
                  cnt_d = '0;
                end
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
          EXPIRED: begin
            state_d = EXPIRED;
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        exp_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        exp_q   <= exp_d;
        done_q  <= done_d;
      end
    end

    assign count[i*CW +: CW] = cnt_q;
    assign done[i]           = done_q;
    assign running[i]        = (state_q == RUN) && select[i];
  end

endmodule

// File: tb/tb_cronometer_bank.sv
// Self-checking bench for cronometer_bank: directed table, corner sequences, randomized run.
module tb_cronometer_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PSW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [PSW-1:0]    presc_div;
  logic [NCH-1:0]    select;
  logic [NCH-1:0]    oneshot;
  logic [NCH-1:0]    clear;
  logic [NCH*CW-1:0] period;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    running;
  logic [NCH*CW-1:0] count;

  cronometer_bank #(.NCH(NCH), .CW(CW), .PSW(PSW)) dut (
    .clk      (clk),
    .rst      (rst),
    .presc_div(presc_div),
    .select   (select),
    .oneshot  (oneshot),
    .clear    (clear),
    .period   (period),
    .done     (done),
    .running  (running),
    .count    (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = counting, 2 = finished; done tracked as a due edge number
  int             m_presc;
  int             m_st  [NCH];
  int             m_cnt [NCH];
  int             m_due [NCH];
  logic [NCH-1:0] m_done;
  int             edge_n = 0;

  task automatic model_edge();
    bit tk;
    int pv;
    tk = (m_presc >= int'(presc_div));
    if (rst) begin
      m_presc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_st[c] = 0; m_cnt[c] = 0; m_due[c] = -1; m_done[c] = 1'b0;
      end
    end else begin
      m_presc = tk ? 0 : m_presc + 1;
      for (int c = 0; c < NCH; c++) begin
        pv = int'(period[c*CW +: CW]);
        if (clear[c]) begin
          m_st[c] = 0; m_cnt[c] = 0; m_due[c] = -1; m_done[c] = 1'b0;
        end else begin
          m_done[c] = (m_due[c] == edge_n);
          if (m_st[c] == 0) begin
            if (select[c]) m_st[c] = 1;
          end else if (m_st[c] == 1 && select[c] && tk) begin
            if (m_cnt[c] >= pv) begin
              m_due[c] = edge_n + 1;
              if (oneshot[c]) m_st[c] = 2;
              else            m_cnt[c] = 0;
            end else begin
              m_cnt[c] = m_cnt[c] + 1;
            end
          end
        end
      end
    end
    edge_n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [NCH*CW-1:0] ec;
    logic [NCH-1:0]    er;
    for (int c = 0; c < NCH; c++) begin
      ec[c*CW +: CW] = CW'(m_cnt[c]);
      er[c]          = (m_st[c] == 1) && select[c];
    end
    chk({tag, "_count"}, 32'(count), 32'(ec));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_running"}, 32'(running), 32'(er));
  endtask

  typedef struct {
    logic          sel;
    logic [CW-1:0] cnt;
    logic          dn;
    logic          run;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int   pulses;
    bit   found;
    logic [CW-1:0] c3;

    // Channel 0, tick every cycle, period 2, periodic; last rows pause then resume
    tbl[0] = '{1'b1, 8'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'd1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'd2, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'd0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'd1, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 8'd2, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'd0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'd1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'd1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 8'd2, 1'b0, 1'b1};

    rst = 1'b1; presc_div = '0; select = '0; oneshot = '0; clear = '0; period = '0;
    m_presc = 0;
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = 0; m_cnt[c] = 0; m_due[c] = -1;
    end
    m_done = '0;
    step(); step();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    rst = 1'b0;

    // Table-driven periodic sequence
    period[0 +: CW] = 8'd2;
    for (int r = 0; r < 10; r++) begin
      select[0] = tbl[r].sel;
      step();
      chk($sformatf("tbl%0d_count0", r), 32'(count[0 +: CW]), 32'(tbl[r].cnt));
      chk($sformatf("tbl%0d_done0", r), 32'(done[0]), 32'(tbl[r].dn));
      chk($sformatf("tbl%0d_run0", r), 32'(running[0]), 32'(tbl[r].run));
      chk_model($sformatf("tbl%0d", r));
    end

    // One-shot on channel 1 with prescaler divisor 3
    select = '0; rst = 1'b1; step(); rst = 1'b0;
    presc_div = 16'd3; period[1*CW +: CW] = 8'd1; oneshot[1] = 1'b1; select[1] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_model("oneshot");
      if (done[1]) pulses++;
    end
    chk("oneshot_pulses", 32'(pulses), 32'd1);
    chk("oneshot_count1", 32'(count[1*CW +: CW]), 32'd1);
    chk("oneshot_running1", 32'(running[1]), 32'd0);

    // Pause a periodic channel at count 1 for 10 cycles
    select = '0; oneshot = '0; clear = '1; presc_div = '0; step(); clear = '0;
    period[0 +: CW] = 8'd5; select[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (count[0 +: CW] == 8'd1) begin found = 1'b1; break; end
    end
    chk("pause_reach1", 32'(found), 32'd1);
    select[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pause_hold_count", 32'(count[0 +: CW]), 32'd1);
      chk("pause_hold_done", 32'(done[0]), 32'd0);
    end
    select[0] = 1'b1;
    step();
    chk("pause_resume_count", 32'(count[0 +: CW]), 32'd2);
    chk_model("pause");

    // Clear in the cycle after an expiry tick kills the pending done
    select = '0; clear = '1; step(); clear = '0;
    period[2*CW +: CW] = 8'd1; select[2] = 1'b1;
    step(); step(); step();
    clear[2] = 1'b1;
    step();
    clear[2] = 1'b0; select[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("clr_done2", 32'(done[2]), 32'd0);
      chk("clr_count2", 32'(count[2*CW +: CW]), 32'd0);
      chk("clr_running2", 32'(running[2]), 32'd0);
    end
    chk_model("clr");

    // Lowering period below the current count forces expiry on the next tick
    select = '0; clear = '1; step(); clear = '0;
    period[3*CW +: CW] = 8'd9; select[3] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      c3 = count[3*CW +: CW];
      if (c3 == 8'd5) begin found = 1'b1; break; end
    end
    chk("pdec_reach5", 32'(found), 32'd1);
    period[3*CW +: CW] = 8'd2;
    step();
    chk("pdec_count3", 32'(count[3*CW +: CW]), 32'd0);
    step();
    chk("pdec_done3", 32'(done[3]), 32'd1);
    chk_model("pdec");

    // Reset mid-run on all channels
    presc_div = 16'd2; select = '1;
    period = {8'd3, 8'd0, 8'd1, 8'd0};
    for (int k = 0; k < 9; k++) begin
      step();
      chk_model("prerst");
    end
    rst = 1'b1;
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_model("postrst");
    end

    // Randomized run against the reference model
    for (int k = 0; k < 3000; k++) begin
      select = NCH'($urandom) | NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        clear[c] = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 49) == 0) oneshot[c] = 1'($urandom);
        if ($urandom_range(0, 19) == 0) period[c*CW +: CW] = CW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 49) == 0) presc_div = PSW'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
      step();
      chk_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cronometer_bank.md
CRONOMETER_BANK -- requirements
Module: cronometer_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent timer channels (1..16).
REQ-002 Parameter CW, default 8: per-channel count and period width (2..16).
REQ-003 Parameter PSW, default 16: prescaler divisor width.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 presc_div  input  PSW: tick generated every presc_div+1 clk cycles.
REQ-007 select  input  NCH: per-channel count enable; low pauses the channel.
REQ-008 oneshot  input  NCH: per-channel mode; 1 = one-shot, 0 = periodic.
REQ-009 clear  input  NCH: per-channel synchronous clear.
REQ-010 period  input  NCH*CW: per-channel terminal count; channel i uses bits [i*CW +: CW].
REQ-011 done  output  NCH: one-cycle expiry pulse per channel.
REQ-012 running  output  NCH: channel in RUN state with select high.
REQ-013 count  output  NCH*CW: current count per channel, same packing as period.

Function
REQ-014 Prescaler: free-running counter 0..presc_div; tick is high in the cycle the counter equals presc_div, which then wraps to 0; presc_div=0 gives a tick every cycle.
REQ-015 If presc_div is lowered below the current prescaler value, the next cycle is treated as terminal (tick, wrap to 0).
REQ-016 Each channel has an FSM with states IDLE, RUN, EXPIRED.
REQ-017 IDLE: count=0; select=1 moves the channel to RUN the next cycle; no counting occurs in the transition cycle.
REQ-018 RUN, select=1, tick, count<period: count increments by 1.
REQ-019 RUN, select=1, tick, count>=period: expiry event; periodic: count<=0, stay RUN; one-shot: count holds, go to EXPIRED.
REQ-020 Expiry period is period+1 ticks; period=0 gives an expiry on every tick.
REQ-021 RUN, select=0: count and state hold, no expiry; resumes on the next tick with select=1.
REQ-022 EXPIRED: count holds, no events; leaves only via clear or rst.
REQ-023 Expiry event is registered into an internal stage; done asserts for exactly one cycle, two clk cycles after the tick cycle of the expiry (e.g. tick in cycle N, done in N+2).
REQ-024 clear[i] has priority over select and tick: channel i goes to IDLE, count=0, and its in-flight expiry stage and done are zeroed the next cycle.
REQ-025 Channels are fully independent; simultaneous expiries on several channels all pulse done in the same cycle.
REQ-026 running[i] = (state==RUN) && select[i], combinational from registered state.
REQ-027 Count arithmetic is unsigned CW-bit; count never exceeds max(period, value held at a period decrease).

Reset
REQ-028 rst high on a clock edge: prescaler=0, all channels IDLE, count=0, expiry stage=0, done=0.
REQ-029 rst overrides clear, select and tick in the same cycle; a done pulse in flight is lost.

Structure
REQ-030 Package cronometer_pkg holds the channel state enum typedef (IDLE, RUN, EXPIRED) and default NCH, CW, PSW constants.
REQ-031 Sub-module cronometer_prescaler (parameter PSW; ports clk, rst, presc_div, tick) implements REQ-014/015 and is instantiated once; channels use a generate loop.

Verification
REQ-032 presc_div=0, period[0]=2, periodic, select[0]=1 -> done[0] pulses every 3 cycles, count[0] cycles 0,1,2.
REQ-033 presc_div=3, period[1]=1, oneshot[1]=1 -> first tick 4 cycles after select; done[1] pulses once, 2 cycles after the second tick; count[1] holds 1; running[1]=0; no further done.
REQ-034 Periodic channel, select dropped for 10 cycles mid-count at count=1 -> count holds 1, no done; resumes incrementing on the first tick after select returns.
REQ-035 clear[2] asserted in the cycle after an expiry tick -> done[2] never pulses, count[2]=0, channel IDLE.
REQ-036 period[3] lowered from 9 to 2 while count[3]=5 -> expiry on the next tick, count[3]=0.
REQ-037 rst asserted mid-run on all channels -> all outputs 0 the next cycle; prescaler restarts from 0.
